// File: rtl/axis_test_pkg.sv
// Shared types and constants for the AXIS test-pattern generator.
// Contents: LFSR tap constants, data-mode and FSM-state enums, and a seed helper.
package axis_test_pkg;

  localparam logic [31:0] LFSR32_TAPS = 32'h8020_0003;
  localparam logic [15:0] LFSR16_TAPS = 16'hB400;

  typedef enum logic {GEN_COUNTER, GEN_LFSR} gen_mode_t;

  typedef enum logic [1:0] {IDLE, OFFER, DONE} gen_state_t;

  // An all-zero Galois LFSR never leaves zero, so a zero seed becomes 1.
  function automatic logic [31:0] nonzero_seed(input logic [31:0] seed);
    return (seed == 32'd0) ? 32'd1 : seed;
  endfunction

endpackage

// File: rtl/helper_lfsr.sv
// Right-shifting Galois LFSR with a step enable.
// Ports:
//   clk_i    clock, rising edge
//   rst_i    synchronous active-high reset, reloads SEED
//   step_i   advance the register by one position this cycle
//   state_o  current register contents
module helper_lfsr #(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = '1,
  parameter logic [WIDTH-1:0] SEED  = '1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             step_i,
  output logic [WIDTH-1:0] state_o
);

  logic [WIDTH-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (step_i) begin
      state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/axis_pattern_generator.sv
// AXIS source emitting a deterministic data sequence (counter or 32-bit LFSR) with
// pseudo-random valid throttling. Never retracts valid; data is frozen while stalled.
// Optional feature macro: AXIS_GEN_LAST_EN adds output_last_o and a packet counter.
// Ports:
//   clk_i           clock, rising edge
//   rst_i           synchronous active-high reset
//   enable_i        allows new beats to be offered
//   output_valid_o  AXIS tvalid
//   output_data_o   AXIS tdata
//   output_ready_i  AXIS tready
//   output_last_o   AXIS tlast (AXIS_GEN_LAST_EN only)
//   done_o          NUM_BEATS beats accepted; sticky until reset
module axis_pattern_generator
  import axis_test_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned MODE       = 0,
  parameter logic [31:0] SEED       = 32'd0,
  parameter int unsigned NUM_BEATS  = 0,
  parameter int unsigned VALID_RATE = 256,
  parameter logic [15:0] THR_SEED   = 16'hACE1,
  parameter int unsigned PACKET_LEN = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  output logic                  output_valid_o,
  output logic [DATA_WIDTH-1:0] output_data_o,
  input  logic                  output_ready_i,
`ifdef AXIS_GEN_LAST_EN
  output logic                  output_last_o,
`endif
  output logic                  done_o
);

  localparam bit UseLfsr = (MODE == 32'(GEN_LFSR));

  gen_state_t  state_q, state_d;
  logic [31:0] beat_cnt_q, beat_cnt_d;
  logic [15:0] thr_state;
  logic        thr_step;
  logic        slot_pass;
  logic        xfer;
  logic        last_beat;
  logic        unused_thr;

  helper_lfsr #(
    .WIDTH (16),
    .TAPS  (LFSR16_TAPS),
    .SEED  (THR_SEED)
  ) u_thr_lfsr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .step_i  (thr_step),
    .state_o (thr_state)
  );

  // 32-bit compare so VALID_RATE=256 passes every slot.
  assign slot_pass  = ({24'd0, thr_state[7:0]} < VALID_RATE);
  assign unused_thr = ^thr_state[15:8];

  assign xfer      = (state_q == OFFER) && output_ready_i;
  assign last_beat = (NUM_BEATS != 0) && (beat_cnt_q == NUM_BEATS - 1);

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    thr_step   = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i) begin
          thr_step = 1'b1;
          if (slot_pass) state_d = OFFER;
        end
      end
      OFFER: begin
        if (output_ready_i) begin
          if (beat_cnt_q != '1) beat_cnt_d = beat_cnt_q + 32'd1;
          if (last_beat) begin
            state_d = DONE;
          end else if (enable_i) begin
            // The transfer edge doubles as the next slot: back-to-back on pass.
            thr_step = 1'b1;
            state_d  = slot_pass ? OFFER : IDLE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      beat_cnt_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign output_valid_o = (state_q == OFFER);
  assign done_o         = (state_q == DONE);

  // Data advances only on a transfer, so it is stable while stalled or idle.
  if (UseLfsr) begin : g_lfsr_data
    logic [31:0] lfsr_state;
    logic        unused_lfsr;

    helper_lfsr #(
      .WIDTH (32),
      .TAPS  (LFSR32_TAPS),
      .SEED  (nonzero_seed(SEED))
    ) u_data_lfsr (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .step_i  (xfer),
      .state_o (lfsr_state)
    );

    assign output_data_o = lfsr_state[DATA_WIDTH-1:0];
    assign unused_lfsr   = ^lfsr_state;
  end else begin : g_cnt_data
    logic [DATA_WIDTH-1:0] data_q, data_d;

    always_comb begin
      data_d = data_q;
      if (xfer) data_d = data_q + DATA_WIDTH'(1);
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        data_q <= SEED[DATA_WIDTH-1:0];
      end else begin
        data_q <= data_d;
      end
    end

    assign output_data_o = data_q;
  end

`ifdef AXIS_GEN_LAST_EN
  logic [31:0] pkt_cnt_q, pkt_cnt_d;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (xfer) begin
      pkt_cnt_d = (pkt_cnt_q == PACKET_LEN - 1) ? 32'd0 : pkt_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pkt_cnt_q <= 32'd0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  // Derived from registered counts only, so it holds with data during a stall.
  assign output_last_o = output_valid_o && ((pkt_cnt_q == PACKET_LEN - 1) || last_beat);
`else
  logic unused_pkt_len;
  assign unused_pkt_len = ^PACKET_LEN;
`endif

endmodule
